cycle_meter: RTL

CYCLE_METER -- requirements
Module: cycle_meter

---
 rtl/cycle_meter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/cycle_meter.sv
// Measures the number of clock cycles between a start pulse and a stop pulse,
// holding each result until the consumer accepts it with a valid/ready handshake.
module cycle_meter #(
  parameter int BIT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 clear,
  input  logic                 start,
  input  logic                 stop,
  output logic [BIT_WIDTH-1:0] elapsed_count,
  output logic                 elapsed_overflow,
  output logic                 elapsed_valid,
  input  logic                 elapsed_ready,
  output logic                 busy
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_COUNTING = 2'd1;
  localparam logic [1:0] ST_HOLD     = 2'd2;

  localparam logic [BIT_WIDTH-1:0] COUNT_MAX = {BIT_WIDTH{1'b1}};
  localparam logic [BIT_WIDTH-1:0] COUNT_ONE = {{(BIT_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]           state_reg, state_next;
  logic [BIT_WIDTH-1:0] counter_reg, counter_next;
  logic                 overflow_reg, overflow_next;
  logic [BIT_WIDTH-1:0] elapsed_count_reg, elapsed_count_next;
  logic                 elapsed_overflow_reg, elapsed_overflow_next;
  logic                 elapsed_valid_reg, elapsed_valid_next;
  logic                 busy_reg, busy_next;

  always_comb begin
    state_next            = state_reg;
    counter_next          = counter_reg;
    overflow_next         = overflow_reg;
    elapsed_count_next    = elapsed_count_reg;
    elapsed_overflow_next = elapsed_overflow_reg;
    elapsed_valid_next    = elapsed_valid_reg;
    busy_next             = busy_reg;

    if (clear) begin
      // Abort keeps the last delivered result visible.
      state_next         = ST_IDLE;
      counter_next       = '0;
      overflow_next      = 1'b0;
      elapsed_valid_next = 1'b0;
      busy_next          = 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (enable && start) begin
            state_next    = ST_COUNTING;
            counter_next  = COUNT_ONE;
            overflow_next = 1'b0;
            busy_next     = 1'b1;
          end
        end

        ST_COUNTING: begin
          if (enable) begin
            if (stop) begin
              // Stop wins over a coincident start.
              state_next            = ST_HOLD;
              elapsed_count_next    = counter_reg;
              elapsed_overflow_next = overflow_reg;
              elapsed_valid_next    = 1'b1;
              busy_next             = 1'b0;
            end else if (start) begin
              counter_next  = COUNT_ONE;
              overflow_next = 1'b0;
            end else if (counter_reg == COUNT_MAX) begin
              overflow_next = 1'b1;
            end else begin
              counter_next = counter_reg + COUNT_ONE;
            end
          end
        end

        ST_HOLD: begin
          if (elapsed_valid_reg && elapsed_ready) begin
            elapsed_valid_next = 1'b0;
            // A start on the accepting edge opens the next measurement directly.
            if (enable && start) begin
              state_next    = ST_COUNTING;
              counter_next  = COUNT_ONE;
              overflow_next = 1'b0;
              busy_next     = 1'b1;
            end else begin
              state_next = ST_IDLE;
            end
          end
        end

        default: begin
          state_next         = ST_IDLE;
          counter_next       = '0;
          overflow_next      = 1'b0;
          elapsed_valid_next = 1'b0;
          busy_next          = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg            <= ST_IDLE;
      counter_reg          <= '0;
      overflow_reg         <= 1'b0;
      elapsed_count_reg    <= '0;
      elapsed_overflow_reg <= 1'b0;
      elapsed_valid_reg    <= 1'b0;
      busy_reg             <= 1'b0;
    end else begin
      state_reg            <= state_next;
      counter_reg          <= counter_next;
      overflow_reg         <= overflow_next;
      elapsed_count_reg    <= elapsed_count_next;
      elapsed_overflow_reg <= elapsed_overflow_next;
      elapsed_valid_reg    <= elapsed_valid_next;
      busy_reg             <= busy_next;
    end
  end

  assign elapsed_count    = elapsed_count_reg;
  assign elapsed_overflow = elapsed_overflow_reg;
  assign elapsed_valid    = elapsed_valid_reg;
  assign busy             = busy_reg;

endmodule
